// File: rtl/dff_pipe_synrst.sv
//==============================================================================
// Module   : dff_pipe_synrst
// Brief    : DEPTH-stage stallable, flushable WIDTH-bit delay line with per-stage
//            valid bits and a programmable reset value. Optional occupancy
//            counter enabled by defining DFF_PIPE_OCC_EN.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module dff_pipe_synrst #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`endif
);

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] vld_r;

  // Each stage loads from its upstream neighbour; stage 0 loads the port.
  // Data shifts regardless of valid so the datapath needs no gating.
  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] w_data_in;
      logic             w_vld_in;

      if (i == 0) begin : g_head
        assign w_data_in = d;
        assign w_vld_in  = d_valid;
      end else begin : g_body
        assign w_data_in = data_r[i-1];
        assign w_vld_in  = vld_r[i-1];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          data_r[i] <= RESET_VAL;
          vld_r[i]  <= 1'b0;
        end else if (flush) begin
          vld_r[i]  <= 1'b0;
        end else if (en) begin
          data_r[i] <= w_data_in;
          vld_r[i]  <= w_vld_in;
        end
      end
    end
  endgenerate

  assign q       = data_r[DEPTH-1];
  assign q_valid = vld_r[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [OCC_W-1:0] occ_r;

  // Entry and exit on the same edge cancel, so the count tracks popcount(vld_r).
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ_r <= '0;
    end else if (en) begin
      case ({d_valid, vld_r[DEPTH-1]})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign occupancy = occ_r;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dff_pipe_synrst.sv
//==============================================================================
// Module   : tb_dff_pipe_synrst
// Brief    : Bench for dff_pipe_synrst: three instances (8x3 reset 00, 8x3 reset
//            FF, 16x1) against a history-based reference model. DFF_PIPE_OCC_EN
//            optionally enables occupancy checks.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_dff_pipe_synrst;

  logic        clk = 1'b0;
  logic        reset, en, flush, d_valid;
  logic [7:0]  d;
  logic [15:0] d_c;

  logic [7:0]  q_a, q_b;
  logic [15:0] q_c;
  logic        qv_a, qv_b, qv_c;
  logic [1:0]  occ_a, occ_b;
  logic        occ_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dff_pipe_synrst #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut_a (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q_a), .q_valid(qv_a)
`ifdef DFF_PIPE_OCC_EN
    , .occupancy(occ_a)
`endif
  );

  dff_pipe_synrst #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hFF)) dut_b (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q_b), .q_valid(qv_b)
`ifdef DFF_PIPE_OCC_EN
    , .occupancy(occ_b)
`endif
  );

  dff_pipe_synrst #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'h0000)) dut_c (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d_c), .d_valid(d_valid),
    .q(q_c), .q_valid(qv_c)
`ifdef DFF_PIPE_OCC_EN
    , .occupancy(occ_c)
`endif
  );

`ifndef DFF_PIPE_OCC_EN
  assign occ_a = '0;
  assign occ_b = '0;
  assign occ_c = '0;
`endif

  // Reference model: a log of every word accepted on an enabled edge since the
  // last reset. The output is the word accepted DEPTH enabled edges ago; a flush
  // just marks everything logged so far as invalid.
  int          m_depth [3] = '{3, 3, 1};
  logic [15:0] m_rst   [3] = '{16'h0000, 16'h00FF, 16'h0000};
  logic [15:0] m_data  [3][256];
  bit          m_vld   [3][256];
  int          m_cnt   [3];
  int          m_mark  [3];

  task automatic model_step(input int k, input bit r, e, f, input logic [15:0] dd, input bit v);
    if (r) begin
      m_cnt[k]  = 0;
      m_mark[k] = 0;
    end else if (f) begin
      m_mark[k] = m_cnt[k];
    end else if (e) begin
      m_data[k][m_cnt[k] % 256] = dd;
      m_vld[k][m_cnt[k] % 256]  = v;
      m_cnt[k]++;
    end
  endtask

  function automatic logic [15:0] exp_q(input int k);
    if (m_cnt[k] >= m_depth[k]) return m_data[k][(m_cnt[k] - m_depth[k]) % 256];
    return m_rst[k];
  endfunction

  function automatic bit exp_v(input int k);
    int idx = m_cnt[k] - m_depth[k];
    return (idx >= 0) && (idx >= m_mark[k]) && m_vld[k][idx % 256];
  endfunction

  function automatic int exp_occ(input int k);
    int lo = m_cnt[k] - m_depth[k];
    int n  = 0;
    if (lo < m_mark[k]) lo = m_mark[k];
    if (lo < 0) lo = 0;
    for (int j = lo; j < m_cnt[k]; j++) if (m_vld[k][j % 256]) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_models();
    check("a.q", 32'(q_a), 32'(exp_q(0)));
    check("a.q_valid", 32'(qv_a), 32'(exp_v(0)));
    check("b.q", 32'(q_b), 32'(exp_q(1)));
    check("b.q_valid", 32'(qv_b), 32'(exp_v(1)));
    check("c.q", 32'(q_c), 32'(exp_q(2)));
    check("c.q_valid", 32'(qv_c), 32'(exp_v(2)));
`ifdef DFF_PIPE_OCC_EN
    check("a.occupancy", 32'(occ_a), 32'(exp_occ(0)));
    check("b.occupancy", 32'(occ_b), 32'(exp_occ(1)));
    check("c.occupancy", 32'(occ_c), 32'(exp_occ(2)));
`endif
  endtask

  // Drive one cycle's inputs, take the edge, then compare 1 time unit later.
  task automatic cycle(input bit r, e, f, input logic [7:0] dd, input bit v,
                       input logic [15:0] dc);
    reset = r; en = e; flush = f; d = dd; d_valid = v; d_c = dc;
    @(posedge clk);
    model_step(0, r, e, f, {8'h00, dd}, v);
    model_step(1, r, e, f, {8'h00, dd}, v);
    model_step(2, r, e, f, dc, v);
    #1;
    check_models();
  endtask

  typedef struct {
    bit         r, e, f;
    logic [7:0] dd;
    bit         v;
    logic [7:0] q;
    bit         qv;
    int         occ;
  } vec_t;

  vec_t tbl[25];

  initial begin
    // Directed table for the 8x3, RESET_VAL=00 instance (expectations after the edge).
    //            r  e  f  d      v  q      qv occ
    tbl[0]  = '{1, 1, 0, 8'hAA, 1, 8'h00, 0, 0};  // reset holds
    tbl[1]  = '{1, 1, 0, 8'hAA, 1, 8'h00, 0, 0};
    tbl[2]  = '{0, 1, 0, 8'hAA, 1, 8'h00, 0, 1};  // two-word stream
    tbl[3]  = '{0, 1, 0, 8'h55, 1, 8'h00, 0, 2};
    tbl[4]  = '{0, 1, 0, 8'h00, 0, 8'hAA, 1, 2};
    tbl[5]  = '{0, 1, 0, 8'h00, 0, 8'h55, 1, 1};
    tbl[6]  = '{0, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    tbl[7]  = '{0, 1, 0, 8'hAA, 1, 8'h00, 0, 1};  // stall mid-flight
    tbl[8]  = '{0, 1, 0, 8'h00, 0, 8'h00, 0, 1};
    tbl[9]  = '{0, 0, 0, 8'hFF, 1, 8'h00, 0, 1};
    tbl[10] = '{0, 0, 0, 8'hFF, 1, 8'h00, 0, 1};
    tbl[11] = '{0, 0, 0, 8'hFF, 1, 8'h00, 0, 1};
    tbl[12] = '{0, 0, 0, 8'hFF, 1, 8'h00, 0, 1};
    tbl[13] = '{0, 1, 0, 8'h00, 0, 8'hAA, 1, 1};
    tbl[14] = '{0, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    tbl[15] = '{0, 1, 0, 8'h11, 1, 8'h00, 0, 1};  // fill then flush
    tbl[16] = '{0, 1, 0, 8'h22, 1, 8'h00, 0, 2};
    tbl[17] = '{0, 1, 0, 8'h33, 1, 8'h11, 1, 3};
    tbl[18] = '{0, 1, 1, 8'h55, 1, 8'h11, 0, 0};
    tbl[19] = '{0, 1, 0, 8'h00, 0, 8'h22, 0, 0};
    tbl[20] = '{0, 1, 0, 8'h00, 0, 8'h33, 0, 0};
    tbl[21] = '{0, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    tbl[22] = '{0, 1, 0, 8'h77, 1, 8'h00, 0, 1};  // reset beats flush and en
    tbl[23] = '{0, 1, 0, 8'h88, 1, 8'h00, 0, 2};
    tbl[24] = '{1, 1, 1, 8'h99, 1, 8'h00, 0, 0};

    reset = 1'b1; en = 1'b0; flush = 1'b0; d = '0; d_valid = 1'b0; d_c = '0;

    for (int i = 0; i < 25; i++) begin
      cycle(tbl[i].r, tbl[i].e, tbl[i].f, tbl[i].dd, tbl[i].v, {tbl[i].dd, ~tbl[i].dd});
      check($sformatf("tbl[%0d].q", i), 32'(q_a), 32'(tbl[i].q));
      check($sformatf("tbl[%0d].q_valid", i), 32'(qv_a), 32'(tbl[i].qv));
`ifdef DFF_PIPE_OCC_EN
      check($sformatf("tbl[%0d].occupancy", i), 32'(occ_a), tbl[i].occ);
`endif
    end
    check("reset_ff.q", 32'(q_b), 32'h0000_00FF);

    // Single-stage 16-bit instance: one enabled edge of latency.
    cycle(1, 0, 0, 8'h00, 0, 16'h0000);
    cycle(0, 1, 0, 8'h12, 1, 16'hBEEF);
    check("depth1.q", 32'(q_c), 32'h0000_BEEF);
    check("depth1.q_valid", 32'(qv_c), 32'h1);
    cycle(0, 0, 0, 8'h34, 0, 16'h1234);
    check("depth1.stall_q", 32'(q_c), 32'h0000_BEEF);

    // Randomized traffic with occasional stalls, flushes and resets.
    for (int n = 0; n < 2000; n++) begin
      logic [7:0]  rd;
      logic [15:0] rc;
      rd = 8'($urandom);
      rc = 16'($urandom);
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 11) == 0, rd, 1'($urandom), rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
